// File: rtl/pc_unit_ctrl.sv
// pc_unit_ctrl: program-counter unit for the multicycle MIPS datapath.
// Holds pc, old_pc (PC of the instruction in flight), epc, cause and,
// optionally, badvaddr. Sequences exception entry (capture, then redirect)
// and ERET return.
//
// Optional feature: define PC_MISALIGN_TRAP_EN to trap PC loads whose target
// is not word aligned. Without it, targets load unmodified and badvaddr is 0.
//
// Handshake: exc_req is a level request sampled only while the unit is in
// RUN (exc_busy=0); its acceptance is implicit at that edge. exc_ack is a
// single-cycle pulse, high exactly in the cycle after pc has been loaded
// with EXC_VECTOR. exc_busy stays high from acceptance until the pulse ends.
module pc_unit_ctrl #(
    parameter int                WIDTH        = 32,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(32'h8000_0180),
    parameter int                CAUSE_W      = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pc_write,
    input  logic                pc_write_cond,
    input  logic                zero,
    input  logic                branch_ne,
    input  logic [1:0]          pc_src,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic [WIDTH-1:0]    alu_out,
    input  logic [WIDTH-1:0]    jump_target,
    input  logic                ir_write,
    input  logic                exc_req,
    input  logic [CAUSE_W-1:0]  exc_cause,
    input  logic                eret,
    output logic [WIDTH-1:0]    pc,
    output logic [WIDTH-1:0]    old_pc,
    output logic [WIDTH-1:0]    epc,
    output logic [CAUSE_W-1:0]  cause,
    output logic [WIDTH-1:0]    badvaddr,
    output logic                exc_ack,
    output logic                exc_busy
);

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        EXC_CAPTURE  = 2'd1,
        EXC_REDIRECT = 2'd2
    } pcState_t;

    pcState_t           state;
    logic               loadEn;
    logic [WIDTH-1:0]   nextPc;

    // Branch qualification and next-PC source selection
    always_comb begin
        loadEn = pc_write | (pc_write_cond & (zero ^ branch_ne));
        nextPc = alu_result;
        unique case (pc_src)
            2'b00:   nextPc = alu_result;
            2'b01:   nextPc = alu_out;
            2'b10:   nextPc = jump_target;
            2'b11:   nextPc = epc;
            default: nextPc = alu_result;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    logic trapMisalign;
    assign trapMisalign = loadEn && (nextPc[1:0] != 2'b00);
`else
    assign badvaddr = '0;
`endif

    assign exc_busy = (state != RUN);

    // PC / exception-register state machine; all outputs are registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            pc       <= RESET_VECTOR;
            old_pc   <= RESET_VECTOR;
            epc      <= '0;
            cause    <= '0;
            exc_ack  <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            badvaddr <= '0;
`endif
        end else begin
            // Fetch-cycle snapshot captures the pre-edge pc in every state
            if (ir_write) begin
                old_pc <= pc;
            end
            exc_ack <= 1'b0;
            case (state)
                RUN: begin
                    if (exc_req) begin
                        epc   <= old_pc;
                        cause <= exc_cause;
                        state <= EXC_CAPTURE;
                    end else if (eret) begin
                        pc <= epc;
`ifdef PC_MISALIGN_TRAP_EN
                    end else if (trapMisalign) begin
                        // Faulting target is recorded, pc is left alone
                        badvaddr <= nextPc;
                        epc      <= old_pc;
                        cause    <= CAUSE_W'(4'h4);
                        state    <= EXC_CAPTURE;
`endif
                    end else if (loadEn) begin
                        pc <= nextPc;
                    end
                end
                EXC_CAPTURE: begin
                    pc      <= EXC_VECTOR;
                    exc_ack <= 1'b1;
                    state   <= EXC_REDIRECT;
                end
                EXC_REDIRECT: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule
